program_memory: RTL

Parametrised Avalon-MM slave memory used for program/data storage behind the host interface. Successor of the fixed 32×128 program store. Generalises data width, depth and read wait states, and replaces the free-running wait counter with a deterministic read state machine. Optionally supports per-byte write enables. Sits on the `s0` slave port of the host bridge.

---
 rtl/program_memory_if.sv | 31 +++
 rtl/program_memory.sv | 110 +++++++++++
 2 files changed

// File: rtl/program_memory_if.sv
// Avalon-MM s0 slave bundle for program_memory.
// s0_byteenable exists only when PROGRAM_MEMORY_BYTEEN_EN is defined.
interface program_memory_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           s0_address;
  logic                  s0_read;
  logic                  s0_write;
  logic [DATA_WIDTH-1:0] s0_writedata;
`ifdef PROGRAM_MEMORY_BYTEEN_EN
  logic [DATA_WIDTH/8-1:0] s0_byteenable;
`endif
  logic [DATA_WIDTH-1:0] s0_readdata;
  logic                  s0_waitrequest;

  modport master (
`ifdef PROGRAM_MEMORY_BYTEEN_EN
    output s0_byteenable,
`endif
    output s0_address, s0_read, s0_write, s0_writedata,
    input  s0_readdata, s0_waitrequest
  );

  modport slave (
`ifdef PROGRAM_MEMORY_BYTEEN_EN
    input  s0_byteenable,
`endif
    input  s0_address, s0_read, s0_write, s0_writedata,
    output s0_readdata, s0_waitrequest
  );
endinterface

// File: rtl/program_memory.sv
// Parametrised Avalon-MM program/data memory with a fixed-latency read FSM.
// Define PROGRAM_MEMORY_BYTEEN_EN to enable per-byte write lanes.
module program_memory_lane #(
  parameter int DEPTH     = 128,
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module program_memory #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  program_memory_if.slave  s0
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int ADDR_BITS = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]       rdata_q;
  logic                        in_range, capture, wr_en, wreq;
  logic [ADDR_BITS-1:0]        addr;
  logic [NUM_LANES-1:0]        lane_we;
  logic [NUM_LANES-1:0][7:0]   lane_rdata;

  // Upper address bits take part in the range check so aliases never hit.
  assign addr     = s0.s0_address[ADDR_BITS-1:0];
  assign in_range = s0.s0_address < 32'(DEPTH);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) rdata_q <= in_range ? lane_rdata : '0;
    end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (s0.s0_read) begin
        state_d = ST_WAIT;
        cnt_d   = 4'(WAIT_CYCLES - 1);
      end
      ST_WAIT:
        if (!s0.s0_read)      state_d = ST_IDLE;
        else if (cnt_q == '0) state_d = ST_DONE;
        else                  cnt_d   = cnt_q - 4'd1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A read wins over a simultaneous write; the write is simply dropped.
  always_comb begin
    capture = 1'b0;
    wr_en   = 1'b0;
    wreq    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wreq  = s0.s0_read;
        wr_en = s0.s0_write & ~s0.s0_read & in_range;
      end
      ST_WAIT: begin
        wreq    = 1'b1;
        capture = s0.s0_read && (cnt_q == '0);
      end
      default: ;
    endcase
  end

  assign s0.s0_waitrequest = wreq & ~reset;
  assign s0.s0_readdata    = rdata_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
`ifdef PROGRAM_MEMORY_BYTEEN_EN
    assign lane_we[i] = wr_en & s0.s0_byteenable[i];
`else
    assign lane_we[i] = wr_en;
`endif
    program_memory_lane #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .addr  (addr),
      .wdata (s0.s0_writedata[8*i +: 8]),
      .rdata (lane_rdata[i])
    );
  end
endmodule
